// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial word stage feeding a bit-serial sequence detector.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_bit,
    output logic             bit_valid,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               rdy_en_q;
    logic               accept;
    logic               last_bit;
`ifdef SERIALIZER_PARITY_EN
    logic               par_q, par_d;
`endif

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign accept   = load_valid && load_ready;

    // rdy_en_q keeps load_ready low while reset is asserted and until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Payload needs no reset: every output that exposes it is gated by state.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef SERIALIZER_PARITY_EN
        par_q   <= par_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_SHIFT: begin
                if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PAR: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            shreg_d = load_data;
`ifdef SERIALIZER_PARITY_EN
            par_d   = ^load_data;
`endif
        end
    end

    always_comb begin
        load_ready = 1'b0;
        ser_bit    = 1'b0;
        bit_valid  = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: load_ready = rdy_en_q;
            S_SHIFT: begin
                bit_valid = 1'b1;
                ser_bit   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
`ifndef SERIALIZER_PARITY_EN
                load_ready = last_bit;
                done       = last_bit;
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            S_PAR: begin
                bit_valid  = 1'b1;
                ser_bit    = par_q;
                load_ready = 1'b1;
                done       = 1'b1;
            end
`endif
            default: load_ready = 1'b0;
        endcase
    end

endmodule
